// File: rtl/pdw_rx.sv
// Serial PDW snapshot receiver: deserializes framed bits into 16-bit payload
// words, checks CRC-16/CCITT over the payload and buffers words in a FIFO.
//
// state | meaning
// IDLE  | waiting for pdw_frame; first high sample is bit 0 of a new frame
// RECV  | shifting in frame bits; low sample ends the frame and posts status
module pdw_rx #(
  parameter int PAYLOAD_BITS = 192,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pdw_data,
  input  logic        pdw_frame,
  output logic [15:0] word_data,
  output logic        word_last,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        len_err,
  output logic        overflow,
  input  logic        clr_status,
  output logic [7:0]  crc_err_cnt
);

  localparam int FRAME_BITS = PAYLOAD_BITS + 16;
  localparam int CW         = $clog2(PAYLOAD_BITS + 18);
  localparam int AW         = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] FRAME_C = CW'(FRAME_BITS);
  localparam logic [CW-1:0] PAY_C   = CW'(PAYLOAD_BITS);
  localparam logic [CW-1:0] LAST_C  = CW'(PAYLOAD_BITS - 1);
  localparam logic [CW-1:0] SAT_C   = CW'(PAYLOAD_BITS + 17);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    shift_q, shift_d;
  logic [15:0]    crc_q, crc_d;
  logic           done_q, done_d;
  logic           crc_ok_q, crc_ok_d;
  logic           len_err_q, len_err_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic [CW-1:0]  bit_idx;
  logic [15:0]    crc_cur;
  logic           fifo_wr;
  logic           fifo_wlast;
  logic [15:0]    fifo_wdata;
  logic           err_inc;

  logic [16:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    fcnt_q, fcnt_d;
  logic           full;
  logic           pop;
  logic           do_wr;
  logic           drop;
  logic [16:0]    head;

  // Frame state machine: a frame always restarts counting and CRC from IDLE,
  // so a frame cut by reset simply resumes as a fresh (short) frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    done_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    len_err_d  = len_err_q;
    fifo_wr    = 1'b0;
    fifo_wlast = 1'b0;
    fifo_wdata = 16'h0000;
    err_inc    = 1'b0;
    bit_idx    = (state_q == IDLE) ? '0 : cnt_q;
    crc_cur    = (state_q == IDLE) ? 16'hFFFF : crc_q;

    if (pdw_frame) begin
      state_d = RECV;
      if (bit_idx < FRAME_C) begin
        shift_d = {shift_q[14:0], pdw_data};
        if (bit_idx < PAY_C) begin
          crc_d = crc_next(crc_cur, pdw_data);
          if (bit_idx[3:0] == 4'hF) begin
            fifo_wr    = 1'b1;
            fifo_wdata = shift_d;
            fifo_wlast = (bit_idx == LAST_C);
          end
        end
      end
      cnt_d = (bit_idx == SAT_C) ? bit_idx : bit_idx + CW'(1);
    end else if (state_q == RECV) begin
      state_d   = IDLE;
      done_d    = 1'b1;
      len_err_d = (cnt_q != FRAME_C);
      crc_ok_d  = !len_err_d && (shift_q == crc_q);
      err_inc   = !crc_ok_d;
      cnt_d     = '0;
      crc_d     = 16'hFFFF;
    end
  end

  assign full  = (fcnt_q == FULL_C);
  assign pop   = word_valid & word_ready;
  assign do_wr = fifo_wr & (!full | pop);
  assign drop  = fifo_wr & full & !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, pop})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Clear wins over a same-cycle drop or error increment.
  always_comb begin
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;
    if (clr_status) begin
      overflow_d = 1'b0;
      err_cnt_d  = 8'h00;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= 16'h0000;
      crc_q      <= 16'h0000;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      len_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      len_err_q  <= len_err_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) fifo_mem[wr_ptr_q] <= {fifo_wlast, fifo_wdata};
  end

  assign head        = fifo_mem[rd_ptr_q];
  assign word_valid  = (fcnt_q != '0);
  assign word_data   = word_valid ? head[15:0] : 16'h0000;
  assign word_last   = word_valid & head[16];
  assign frame_done  = done_q;
  assign crc_ok      = crc_ok_q;
  assign len_err     = len_err_q;
  assign overflow    = overflow_q;
  assign crc_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_pdw_rx.sv
// Scoreboard bench for pdw_rx: a driver serializes frames and queues expected
// words/status; a negedge monitor models FIFO occupancy and checks outputs.
module tb_pdw_rx;

  localparam int P     = 192;
  localparam int NW    = P / 16;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        pdw_data;
  logic        pdw_frame;
  logic [15:0] word_data;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;
  logic        frame_done;
  logic        crc_ok;
  logic        len_err;
  logic        overflow;
  logic        clr_status;
  logic [7:0]  crc_err_cnt;

  pdw_rx #(.PAYLOAD_BITS(P), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pdw_data(pdw_data), .pdw_frame(pdw_frame),
    .word_data(word_data), .word_last(word_last), .word_valid(word_valid),
    .word_ready(word_ready), .frame_done(frame_done), .crc_ok(crc_ok),
    .len_err(len_err), .overflow(overflow), .clr_status(clr_status),
    .crc_err_cnt(crc_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic        fb [0:1023];
  logic [16:0] pend_q [$];
  logic [16:0] exp_q  [$];
  logic [1:0]  st_q   [$];

  int   exp_cnt;
  bit   exp_ovf, held_ok, held_len, prev_clr, prev_drop;
  int   pop_cnt = 0;
  int   fd_cnt  = 0;
  bit   rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_word(input int pos);
    logic [15:0] w;
    for (int b = 0; b < 16; b++) w[15-b] = fb[pos+b];
    return w;
  endfunction

  task automatic put_word(input int pos, input logic [15:0] w);
    for (int b = 0; b < 16; b++) fb[pos+b] = w[15-b];
  endtask

  // Word-at-a-time CRC-16/CCITT-FALSE over the payload starting at 'start'.
  function automatic logic [15:0] crc_words(input int start);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < NW; k++) begin
      c = c ^ get_word(start + 16*k);
      for (int s = 0; s < 16; s++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  task automatic set_crc();
    put_word(P, crc_words(0));
  endtask

  task automatic build_frame_a();
    put_word(0, 16'h1234);
    put_word(16, 16'h5678);
    for (int k = 0; k < 10; k++) put_word(32 + 16*k, 16'(k + 1));
    set_crc();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_word_valid"}, 32'(word_valid), 0);
    chk({tag, "_word_last"}, 32'(word_last), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_crc_ok"}, 32'(crc_ok), 0);
    chk({tag, "_len_err"}, 32'(len_err), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_crc_err_cnt"}, 32'(crc_err_cnt), 0);
  endtask

  // Drive fb[0..len-1]; rst_at >= 0 pulses reset for two bits starting there.
  task automatic run_frame(input int len, input int rst_at, input bit clr_end);
    int seg, rel, sl;
    bit in_rst, le, ok;
    seg = 0;
    in_rst = 0;
    for (int j = 0; j < len; j++) begin
      @(posedge clk); #1;
      pdw_frame = 1'b1;
      pdw_data  = fb[j];
      if (j == rst_at) begin
        rst_n = 1'b0;
        in_rst = 1;
        #1;
        check_zero("rst_mid");
      end else if (in_rst && j == rst_at + 2) begin
        rst_n = 1'b1;
        in_rst = 0;
        seg = j;
      end
      if (!in_rst) begin
        rel = j - seg;
        if (rel < P && rel % 16 == 15)
          pend_q.push_back({(rel == P-1), get_word(seg + rel - 15)});
      end
    end
    @(posedge clk); #1;
    pdw_frame = 1'b0;
    pdw_data  = 1'b0;
    if (clr_end) clr_status = 1'b1;
    sl = len - seg;
    le = (sl != P + 16);
    ok = !le && (get_word(seg + P) == crc_words(seg));
    st_q.push_back({ok, le});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pdw_frame = 1'b0;
      clr_status = 1'b0;
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && pend_q.size() == 0 && st_q.size() == 0) break;
    end
    chk({tag, "_drain_timeout"}, 32'(k >= 400), 0);
    idle(2);
  endtask

  // Monitor: apply the effect of the edge just passed, compare, then decide
  // the pop and write that the coming edge will perform.
  always @(negedge clk) begin
    logic [16:0] e, w;
    logic [1:0]  s;
    bit          drop;
    if (!rst_n) begin
      exp_q.delete(); pend_q.delete(); st_q.delete();
      exp_cnt = 0; exp_ovf = 0; held_ok = 0; held_len = 0;
      prev_clr = 0; prev_drop = 0;
    end else begin
      if (prev_clr) begin
        exp_cnt = 0;
        exp_ovf = 0;
      end else if (prev_drop) begin
        exp_ovf = 1;
      end
      if (frame_done) begin
        fd_cnt++;
        if (st_q.size() == 0) begin
          chk("spurious_frame_done", 32'(frame_done), 0);
        end else begin
          s = st_q.pop_front();
          held_ok  = s[1];
          held_len = s[0];
          if (!s[1] && !prev_clr && exp_cnt != 255) exp_cnt++;
        end
      end
      chk("word_valid", 32'(word_valid), 32'(exp_q.size() != 0));
      chk("crc_ok", 32'(crc_ok), 32'(held_ok));
      chk("len_err", 32'(len_err), 32'(held_len));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      chk("crc_err_cnt", 32'(crc_err_cnt), 32'(exp_cnt));
      if (word_valid && word_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pop_cnt++;
        chk("word_last_data", {15'd0, word_last, word_data}, {15'd0, e});
      end
      drop = 0;
      if (pend_q.size() != 0) begin
        w = pend_q.pop_front();
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else drop = 1;
      end
      prev_clr  = clr_status;
      prev_drop = drop;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) word_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int p0, f0, len, r;
    rst_n = 1'b0; pdw_data = 1'b0; pdw_frame = 1'b0;
    word_ready = 1'b1; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Reference frame, ready high.
    build_frame_a();
    p0 = pop_cnt;
    run_frame(P + 16, -1, 0);
    wait_drain("frame_a");
    chk("frame_a_words", pop_cnt - p0, NW);

    // Same frame, CRC LSB flipped.
    fb[P + 15] = ~fb[P + 15];
    run_frame(P + 16, -1, 0);
    wait_drain("bad_crc");
    chk("bad_crc_cnt", 32'(crc_err_cnt), 1);
    chk("bad_crc_ok", 32'(crc_ok), 0);

    // Short frame of 100 bits.
    build_frame_a();
    p0 = pop_cnt;
    run_frame(100, -1, 0);
    wait_drain("short");
    chk("short_words", pop_cnt - p0, 6);
    chk("short_len_err", 32'(len_err), 1);
    chk("short_cnt", 32'(crc_err_cnt), 2);

    // Two good frames with no consumer: FIFO fills and drops.
    word_ready = 1'b0;
    run_frame(P + 16, -1, 0);
    run_frame(P + 16, -1, 0);
    idle(4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_valid", 32'(word_valid), 1);
    @(posedge clk); #1; clr_status = 1'b1;
    @(posedge clk); #1; clr_status = 1'b0;
    #1;
    chk("ovf_cleared", 32'(overflow), 0);
    chk("cnt_cleared", 32'(crc_err_cnt), 0);
    p0 = pop_cnt;
    word_ready = 1'b1;
    wait_drain("ovf");
    chk("ovf_words_held", pop_cnt - p0, DEPTH);

    // Back-to-back good frames, one-cycle gap.
    p0 = pop_cnt; f0 = fd_cnt;
    run_frame(P + 16, -1, 0);
    run_frame(P + 16, -1, 0);
    wait_drain("b2b");
    chk("b2b_words", pop_cnt - p0, 2 * NW);
    chk("b2b_frame_done", fd_cnt - f0, 2);
    chk("b2b_crc_ok", 32'(crc_ok), 1);

    // Reset at bit 50 with words pending in the FIFO.
    word_ready = 1'b0;
    run_frame(P + 16, 50, 0);
    idle(2);
    chk("rst_tail_len_err", 32'(len_err), 1);
    word_ready = 1'b1;
    wait_drain("rst_tail");

    // Saturate the error counter with tiny frames.
    for (int i = 0; i < 260; i++) run_frame(5, -1, 0);
    wait_drain("sat");
    chk("cnt_saturated", 32'(crc_err_cnt), 255);

    // Clear coincident with a bad frame end must win.
    run_frame(5, -1, 1);
    idle(3);
    chk("clr_priority_cnt", 32'(crc_err_cnt), 0);

    // Randomized frames, random consumer.
    rand_rdy = 1;
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r == 6)      len = $urandom_range(1, P + 15);
      else if (r == 7) len = $urandom_range(P + 17, P + 40);
      else             len = P + 16;
      for (int b = 0; b < P; b++) fb[b] = 1'($urandom_range(0, 1));
      set_crc();
      for (int b = P + 16; b < len; b++) fb[b] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 15);
        fb[P + r] = ~fb[P + r];
      end
      run_frame(len, -1, 0);
      idle($urandom_range(0, 2));
    end
    rand_rdy = 0;
    @(posedge clk); #1;
    word_ready = 1'b1;
    wait_drain("random");
    chk("status_pending", st_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
